// File: rtl/branch_resolve_unit_if.sv
// Bundle between the Memory stage, the branch predictor update port and fetch redirect logic.
// The pipeline (master) drives the slot inputs; the resolve unit (slave) drives updates/redirect.
interface branch_resolve_unit_if #(
   parameter int PC_W = 8
);
   // valid_i qualifies every other slot signal in the same cycle; there is no ready,
   // the unit accepts every valid slot while not busy and silently drops slots while busy.
   logic            valid1, valid2;
   logic            isBranch1, isBranch2;
   logic [PC_W-1:0] pcM1, pcM2;
   logic            taken1, taken2;
   logic [PC_W-1:0] targetM1, targetM2;
   logic            predTaken1, predTaken2;
   logic [PC_W-1:0] predTarget1, predTarget2;

   logic            branch1, branch2;
   logic            branch_taken1, branch_taken2;
   logic [PC_W-1:0] pcU1, pcU2;
   logic [PC_W-1:0] targetU1, targetU2;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            flush;
   logic            busy;

   modport master (
      output valid1, valid2, isBranch1, isBranch2, pcM1, pcM2, taken1, taken2,
             targetM1, targetM2, predTaken1, predTaken2, predTarget1, predTarget2,
      input  branch1, branch2, branch_taken1, branch_taken2, pcU1, pcU2,
             targetU1, targetU2, redirect_valid, redirect_pc, flush, busy
   );

   modport slave (
      input  valid1, valid2, isBranch1, isBranch2, pcM1, pcM2, taken1, taken2,
             targetM1, targetM2, predTaken1, predTaken2, predTarget1, predTarget2,
      output branch1, branch2, branch_taken1, branch_taken2, pcU1, pcU2,
             targetU1, targetU2, redirect_valid, redirect_pc, flush, busy
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Dual-issue Memory-stage branch resolution: predictor updates plus redirect/flush on mispredict.
// Optional performance counters are enabled with the BRU_PERF_CNT_EN macro.
module branch_resolve_unit #(
   parameter int PC_W         = 8,
   parameter int FLUSH_CYCLES = 2
`ifdef BRU_PERF_CNT_EN
   ,
   parameter int CNT_W        = 16
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_resolve_unit_if.slave bus,
   output logic                 dbg_state
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     perf_branches,
   output logic [CNT_W-1:0]     perf_mispredicts
`endif
);

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   state_t          state, state_n;
   logic [3:0]      cnt, cnt_n;
   logic            redir_n;
   logic [PC_W-1:0] rpc_n;

   logic            is_idle;
   logic            res1, res2, mis1, mis2;
   logic [PC_W-1:0] npc1, npc2;

   logic            branch1_q, branch2_q, taken1_q, taken2_q;
   logic [PC_W-1:0] pc1_q, pc2_q, tgt1_q, tgt2_q;
   logic            redirect_valid_q;
   logic [PC_W-1:0] redirect_pc_q;

   // Slot 2 is younger, so a slot-1 mispredict makes it wrong-path.
   assign is_idle = (state == IDLE);
   assign res1    = is_idle & bus.valid1 & bus.isBranch1;
   assign mis1    = res1 & ((bus.taken1 != bus.predTaken1) |
                            (bus.taken1 & bus.predTaken1 & (bus.targetM1 != bus.predTarget1)));
   assign res2    = is_idle & bus.valid2 & bus.isBranch2 & ~mis1;
   assign mis2    = res2 & ((bus.taken2 != bus.predTaken2) |
                            (bus.taken2 & bus.predTaken2 & (bus.targetM2 != bus.predTarget2)));
   assign npc1    = bus.taken1 ? bus.targetM1 : PC_W'(bus.pcM1 + PC_W'(1));
   assign npc2    = bus.taken2 ? bus.targetM2 : PC_W'(bus.pcM2 + PC_W'(1));

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      redir_n = 1'b0;
      rpc_n   = redirect_pc_q;
      case (state)
         IDLE: begin
            if (mis1 | mis2) begin
               redir_n = 1'b1;
               rpc_n   = mis1 ? npc1 : npc2;
               cnt_n   = 4'(FLUSH_CYCLES);
               state_n = FLUSH;
            end
         end
         FLUSH: begin
            if (cnt == 4'd1) begin
               cnt_n   = 4'd0;
               state_n = IDLE;
            end else begin
               cnt_n = 4'(cnt - 4'd1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         cnt              <= 4'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         branch1_q        <= 1'b0;
         branch2_q        <= 1'b0;
         taken1_q         <= 1'b0;
         taken2_q         <= 1'b0;
         pc1_q            <= '0;
         pc2_q            <= '0;
         tgt1_q           <= '0;
         tgt2_q           <= '0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         redirect_valid_q <= redir_n;
         redirect_pc_q    <= rpc_n;
         branch1_q        <= res1;
         branch2_q        <= res2;
         taken1_q         <= bus.taken1;
         taken2_q         <= bus.taken2;
         pc1_q            <= bus.pcM1;
         pc2_q            <= bus.pcM2;
         tgt1_q           <= bus.targetM1;
         tgt2_q           <= bus.targetM2;
      end
   end

   assign bus.branch1        = branch1_q;
   assign bus.branch2        = branch2_q;
   assign bus.branch_taken1  = taken1_q;
   assign bus.branch_taken2  = taken2_q;
   assign bus.pcU1           = pc1_q;
   assign bus.pcU2           = pc2_q;
   assign bus.targetU1       = tgt1_q;
   assign bus.targetU2       = tgt2_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.flush          = (state == FLUSH);
   assign bus.busy           = (state == FLUSH);
   assign dbg_state          = state;

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W:0] br_sum, mp_sum;

   // One extra bit catches the carry so the counters stick at all-ones.
   assign br_sum = {1'b0, perf_branches} + (CNT_W+1)'(res1) + (CNT_W+1)'(res2);
   assign mp_sum = {1'b0, perf_mispredicts} + (CNT_W+1)'(redir_n);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         perf_branches    <= br_sum[CNT_W] ? '1 : br_sum[CNT_W-1:0];
         perf_mispredicts <= mp_sum[CNT_W] ? '1 : mp_sum[CNT_W-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected updates/redirects are queued at issue time
// and a negedge monitor pops and compares whenever the unit presents an update or redirect.
module tb_branch_resolve_unit;
   localparam int PC_W  = 8;
   localparam int EXP_W = 2 * (2 + 2 * PC_W) + 1 + PC_W;

   typedef struct packed {
      logic            v;
      logic            br;
      logic [PC_W-1:0] pc;
      logic            t;
      logic [PC_W-1:0] tg;
      logic            pt;
      logic [PC_W-1:0] ptg;
   } slot_t;

   logic clk;
   logic reset;
   logic dbg_state;
   int   checks = 0;
   int   errors = 0;
   logic [EXP_W-1:0] exp_q[$];

   branch_resolve_unit_if #(.PC_W(PC_W)) bus ();

`ifdef BRU_PERF_CNT_EN
   logic [15:0] perf_branches, perf_mispredicts;
   branch_resolve_unit dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );
`else
   branch_resolve_unit dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
   );
`endif

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [EXP_W-1:0] pack(
      input logic b1, input logic t1, input logic [PC_W-1:0] pc1, input logic [PC_W-1:0] tg1,
      input logic b2, input logic t2, input logic [PC_W-1:0] pc2, input logic [PC_W-1:0] tg2,
      input logic rv, input logic [PC_W-1:0] rpc);
      return {b1, b1 & t1, b1 ? pc1 : 8'h00, b1 ? tg1 : 8'h00,
              b2, b2 & t2, b2 ? pc2 : 8'h00, b2 ? tg2 : 8'h00,
              rv, rv ? rpc : 8'h00};
   endfunction

   function automatic slot_t mk(input logic v, input logic br, input logic [PC_W-1:0] pc,
                                input logic t, input logic [PC_W-1:0] tg,
                                input logic pt, input logic [PC_W-1:0] ptg);
      slot_t s;
      s = '{v: v, br: br, pc: pc, t: t, tg: tg, pt: pt, ptg: ptg};
      return s;
   endfunction

   // driver tasks
   task automatic drive(input slot_t s1, input slot_t s2);
      bus.valid1 = s1.v;  bus.isBranch1 = s1.br; bus.pcM1 = s1.pc; bus.taken1 = s1.t;
      bus.targetM1 = s1.tg; bus.predTaken1 = s1.pt; bus.predTarget1 = s1.ptg;
      bus.valid2 = s2.v;  bus.isBranch2 = s2.br; bus.pcM2 = s2.pc; bus.taken2 = s2.t;
      bus.targetM2 = s2.tg; bus.predTaken2 = s2.pt; bus.predTarget2 = s2.ptg;
   endtask

   task automatic issue(input slot_t s1, input slot_t s2);
      drive(s1, s2);
      @(posedge clk);
      #1;
      drive('0, '0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flush_seq(input string name);
      @(negedge clk);
      chk({name, "_flush_c1"}, {bus.flush, bus.busy}, 2'b11);
      @(negedge clk);
      chk({name, "_flush_c2"}, {bus.flush, bus.busy}, 2'b11);
      @(negedge clk);
      chk({name, "_flush_end"}, {bus.flush, bus.busy}, 2'b00);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [EXP_W-1:0] act, exp;
      if (reset === 1'b1 && (bus.branch1 || bus.branch2 || bus.redirect_valid)) begin
         act = pack(bus.branch1, bus.branch_taken1, bus.pcU1, bus.targetU1,
                    bus.branch2, bus.branch_taken2, bus.pcU2, bus.targetU2,
                    bus.redirect_valid, bus.redirect_pc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h expected none", act);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               errors++;
               $display("FAIL update_redirect: got %h expected %h", act, exp);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      drive('0, '0);
      repeat (3) @(negedge clk);
      chk("rst_branch",   {bus.branch1, bus.branch2}, 2'b00);
      chk("rst_redirect", {bus.redirect_valid, bus.redirect_pc}, 9'h0);
      chk("rst_flush",    {bus.flush, bus.busy, dbg_state}, 3'b000);
      chk("rst_update",   {bus.pcU1, bus.targetU1, bus.pcU2, bus.targetU2}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // correctly predicted taken branch
      exp_q.push_back(pack(1, 1, 8'h10, 8'h40, 0, 0, 0, 0, 0, 0));
      issue(mk(1, 1, 8'h10, 1, 8'h40, 1, 8'h40), '0);
      @(negedge clk);
      chk("t1_no_flush", {bus.flush, bus.busy}, 2'b00);

      // predicted taken, actually not taken
      exp_q.push_back(pack(1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 1, 8'h21));
      issue(mk(1, 1, 8'h20, 0, 8'h00, 1, 8'h66), '0);
      flush_seq("t2");

      // both mispredict: slot 1 wins, slot 2 squashed
      exp_q.push_back(pack(1, 1, 8'h50, 8'h80, 0, 0, 0, 0, 1, 8'h80));
      issue(mk(1, 1, 8'h50, 1, 8'h80, 0, 8'h00), mk(1, 1, 8'h51, 0, 8'h00, 1, 8'h90));
      flush_seq("t3");

      // slot 1 correct, slot 2 wrong target
      exp_q.push_back(pack(1, 0, 8'h28, 8'h00, 1, 1, 8'h30, 8'h05, 1, 8'h05));
      issue(mk(1, 1, 8'h28, 0, 8'h00, 0, 8'h00), mk(1, 1, 8'h30, 1, 8'h05, 1, 8'h07));
      flush_seq("t4");

      // both correct; predicted target of a not-taken branch is irrelevant
      exp_q.push_back(pack(1, 1, 8'h08, 8'h12, 1, 0, 8'h09, 8'h00, 0, 0));
      issue(mk(1, 1, 8'h08, 1, 8'h12, 1, 8'h12), mk(1, 1, 8'h09, 0, 8'h00, 0, 8'h33));
      @(negedge clk);
      chk("both_ok_no_flush", {bus.flush, bus.busy}, 2'b00);

      // invalid slot and non-branch slot are ignored
      issue(mk(0, 1, 8'hA0, 1, 8'hB0, 0, 8'h00), mk(1, 0, 8'hA1, 1, 8'hC0, 0, 8'h00));
      @(negedge clk);
      chk("ignored_no_flush", {bus.flush, bus.busy}, 2'b00);

      // mispredict offered during flush is wrong-path
      exp_q.push_back(pack(1, 0, 8'h70, 8'h00, 0, 0, 0, 0, 1, 8'h71));
      issue(mk(1, 1, 8'h70, 0, 8'h00, 1, 8'h00), '0);
      issue(mk(1, 1, 8'h90, 1, 8'hA0, 0, 8'h00), '0);
      @(negedge clk);
      chk("t5_flush_c2", {bus.flush, bus.busy, dbg_state}, 3'b111);
      @(negedge clk);
      chk("t5_flush_end", {bus.flush, bus.busy, dbg_state}, 3'b000);

      // not-taken fall-through wraps at the top of the PC space
      exp_q.push_back(pack(1, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 1, 8'h00));
      issue(mk(1, 1, 8'hFF, 0, 8'h00, 1, 8'h10), '0);
      flush_seq("wrap");

`ifdef BRU_PERF_CNT_EN
      chk("perf_branches",    perf_branches, 32'd9);
      chk("perf_mispredicts", perf_mispredicts, 32'd5);
`endif

      // reset asserted during the first flush cycle
      exp_q.push_back(pack(1, 1, 8'h40, 8'h44, 0, 0, 0, 0, 1, 8'h44));
      issue(mk(1, 1, 8'h40, 1, 8'h44, 0, 8'h00), '0);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_flush",  {bus.flush, bus.busy, dbg_state}, 3'b000);
      chk("midrst_out",    {bus.branch1, bus.redirect_valid, bus.redirect_pc}, 10'h0);
`ifdef BRU_PERF_CNT_EN
      chk("midrst_perf",   {perf_branches, perf_mispredicts}, 32'h0);
`endif
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {bus.flush, bus.busy}, 2'b00);

      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
